// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// muldiv_sequencer: iterative radix-2 unsigned multiplier / restoring divider.
// One step per cycle for WIDTH cycles, a one-cycle DONE, then back to IDLE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_srcA,
  input  logic [WIDTH-1:0] i_srcB,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_divByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_count;
  logic             r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;

  logic             w_lastStep;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divDiff;
  logic             w_divFits;
  logic [WIDTH-1:0] w_nextAcc;
  logic [WIDTH-1:0] w_nextQ;

  assign w_lastStep = (r_state == RUN) && (r_count == CW'(WIDTH - 1));
  assign o_busy     = (r_state == RUN);
  assign o_done     = (r_state == DONE);

  // Multiply: {acc,q} shifts right, adding the multiplicand when q[0] is set.
  // Divide: {acc,q} shifts left, subtracting the divisor when it fits.
  assign w_mulSum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_divShift = {r_acc, r_q[WIDTH-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_b};
  assign w_divFits  = (w_divShift >= {1'b0, r_b});

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: accept Start only in IDLE, leave RUN after WIDTH steps.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = RUN;
      RUN:     if (w_lastStep) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // One radix-2 step of the selected operation. A zero divisor always "fits",
  // which naturally yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    w_nextAcc = r_acc;
    w_nextQ   = r_q;
    if (r_op) begin
      if (w_divFits) begin
        w_nextAcc = w_divDiff[WIDTH-1:0];
        w_nextQ   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_nextAcc = w_divShift[WIDTH-1:0];
        w_nextQ   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_nextAcc = w_mulSum[WIDTH:1];
      w_nextQ   = {w_mulSum[0], r_q[WIDTH-1:1]};
    end
  end

  // Working registers: operands are captured at acceptance so later input
  // changes cannot disturb the running operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_op    <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_count <= '0;
      r_op    <= i_op;
      r_b     <= i_srcB;
      r_acc   <= '0;
      r_q     <= i_srcA;
    end else if (r_state == RUN) begin
      r_count <= r_count + CW'(1);
      r_acc   <= w_nextAcc;
      r_q     <= w_nextQ;
    end
  end

  // Result registers change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hi        <= '0;
      o_lo        <= '0;
      o_divByZero <= 1'b0;
    end else if (w_lastStep) begin
      o_hi        <= w_nextAcc;
      o_lo        <= w_nextQ;
      o_divByZero <= r_op && (r_b == '0);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for muldiv_sequencer: expected results are computed with
// native arithmetic when an operation is issued and compared at Done.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] srcA = '0;
  logic [WIDTH-1:0] srcB = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divByZero;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
  } exp_t;

  exp_t             expQ[$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] lastHi = '0;
  logic [WIDTH-1:0] lastLo = '0;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(start),
    .i_op(op),
    .i_srcA(srcA),
    .i_srcB(srcB),
    .o_busy(busy),
    .o_done(done),
    .o_hi(hi),
    .o_lo(lo),
    .o_divByZero(divByZero)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one operation at a negedge, follows it through RUN, checks the
  // scoreboard entry at Done and returns at the Done negedge.
  task automatic applyStimulus(input logic opIn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int expWait, input int injectAt);
    exp_t        e;
    logic [63:0] p;
    int          waited;
    int          busyCnt;
    logic        holdOk;
    if (!opIn) begin
      p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dbz = 1'b0;
    end else if (b == 0) begin
      e.hi = a;
      e.lo = '1;
      e.dbz = 1'b1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.dbz = 1'b0;
    end
    expQ.push_back(e);
    start = 1'b1;
    op = opIn;
    srcA = a;
    srcB = b;
    waited = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!busy && waited < 4);
    start = 1'b0;
    checkOutput("acceptLatency", 64'(waited), 64'(expWait));
    busyCnt = 0;
    holdOk = 1'b1;
    while (busy && busyCnt < 100) begin
      busyCnt++;
      if (done) holdOk = 1'b0;
      if (hi !== lastHi || lo !== lastLo) holdOk = 1'b0;
      if (busyCnt == injectAt) begin
        start = 1'b1;
        op = ~opIn;
        srcA = $urandom;
        srcB = $urandom;
      end else begin
        start = 1'b0;
        op = 1'($urandom);
        srcA = $urandom;
        srcB = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("busyCycles", 64'(busyCnt), 64'(WIDTH));
    checkOutput("holdDuringRun", 64'(holdOk), 64'd1);
    checkOutput("donePulse", 64'(done), 64'd1);
    e = expQ.pop_front();
    checkOutput("resultHi", 64'(hi), 64'(e.hi));
    checkOutput("resultLo", 64'(lo), 64'(e.lo));
    checkOutput("divByZero", 64'(divByZero), 64'(e.dbz));
    lastHi = e.hi;
    lastLo = e.lo;
  endtask

  // Advances one cycle past Done and confirms the block is idle again.
  task automatic expectIdle(input string tag);
    @(negedge clk);
    checkOutput(tag, 64'({busy, done}), 64'd0);
  endtask

  // Starts a multiply, resets it at RUN cycle 15 and checks the abort.
  task automatic applyAbort(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int   cnt;
    logic seen;
    start = 1'b1;
    op = 1'b0;
    srcA = a;
    srcB = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (cnt < 15) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    checkOutput("abortPreBusy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    checkOutput("abortHi", 64'(hi), 64'd0);
    checkOutput("abortLo", 64'(lo), 64'd0);
    checkOutput("abortDbz", 64'(divByZero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checkOutput("noDoneAfterAbort", 64'(seen), 64'd0);
    lastHi = '0;
    lastLo = '0;
  endtask

  // Bounded run time so a hung design still ends the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rop;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetHi", 64'(hi), 64'd0);
    checkOutput("resetLo", 64'(lo), 64'd0);
    checkOutput("resetDbz", 64'(divByZero), 64'd0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 32'd7, 32'd6, 1, 0);
    expectIdle("idleAfterMul7x6");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    expectIdle("idleAfterMulMax");
    applyStimulus(1'b1, 32'd100, 32'd7, 1, 0);
    applyStimulus(1'b1, 32'd5, 32'd9, 2, 0);
    expectIdle("idleAfterDiv5by9");
    applyStimulus(1'b1, 32'd1234, 32'd0, 1, 0);
    expectIdle("idleAfterDivZero");
    applyStimulus(1'b0, 32'd2, 32'd3, 1, 0);
    expectIdle("idleAfterMul2x3");
    applyStimulus(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 10);
    expectIdle("idleAfterIgnoredStart");

    for (int i = 0; i < 4; i++) begin
      rop = 1'(i % 2);
      ra = $urandom;
      rb = rop ? 32'($urandom_range(0, 300)) : $urandom;
      applyStimulus(rop, ra, rb, 1, 0);
      expectIdle("idleAfterRandom");
    end

    applyAbort(32'd11, 32'd13);
    applyStimulus(1'b0, 32'd3, 32'd3, 1, 0);
    expectIdle("idleAfterMul3x3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
